// File: rtl/thread_register_file.sv
// Per-thread register file for one compute lane: sixteen registers, R0-R12
// general purpose, R13-R15 read-only (%blockIdx, %blockDim, %threadIdx).
// Latency: rs/rt registered 1 cycle after a REQUEST edge; writes land at the
// UPDATE edge and are visible to the next REQUEST (no bypass).
// Backpressure: none; enable=0 freezes every register, rs and rt.
//
// Ports:
//   clk, reset (async active-low)
//   enable          lane active
//   block_id        mirrored into R13 every enabled edge
//   core_state      core FSM state; REQUEST=011 reads, UPDATE=110 writes
//   decoded_*       rs/rt/rd addresses, write enable, write-source mux, immediate
//   alu_out/lsu_out write-back sources
//   rs, rt          registered operands to ALU/LSU
module thread_register_file #(
  parameter int THREADS_PER_BLOCK = 4,
  parameter int THREAD_ID         = 0,
  parameter int DATA_BITS         = 8
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 enable,
  input  logic [7:0]           block_id,
  input  logic [2:0]           core_state,
  input  logic [3:0]           decoded_rs_address,
  input  logic [3:0]           decoded_rt_address,
  input  logic [3:0]           decoded_rd_address,
  input  logic                 decoded_reg_write_enable,
  input  logic [1:0]           decoded_reg_input_mux,
  input  logic [DATA_BITS-1:0] decoded_immediate,
  input  logic [DATA_BITS-1:0] alu_out,
  input  logic [DATA_BITS-1:0] lsu_out,
  output logic [DATA_BITS-1:0] rs,
  output logic [DATA_BITS-1:0] rt
);

  localparam logic [2:0] STATE_REQUEST = 3'b011;
  localparam logic [2:0] STATE_UPDATE  = 3'b110;

  localparam int         NUM_GPR  = 13;
  localparam logic [3:0] LAST_GPR = 4'd12;

  localparam logic [1:0] SRC_ALU = 2'b00;
  localparam logic [1:0] SRC_LSU = 2'b01;
  localparam logic [1:0] SRC_IMM = 2'b10;

  // R14/R15 never change after reset, so they are plain constants rather
  // than flops.
  localparam logic [DATA_BITS-1:0] BLOCK_DIM  = DATA_BITS'(THREADS_PER_BLOCK);
  localparam logic [DATA_BITS-1:0] THREAD_IDX = DATA_BITS'(THREAD_ID);

  logic [DATA_BITS-1:0] gpr [NUM_GPR];
  logic [DATA_BITS-1:0] block_idx;

  logic [DATA_BITS-1:0] rs_sel;
  logic [DATA_BITS-1:0] rt_sel;
  logic [DATA_BITS-1:0] wr_data;
  logic                 wr_en;

  // Read ports. R13 is read from the flop, so a REQUEST sees the block index
  // captured before this edge, not the live block_id input.
  always_comb begin
    rs_sel = '0;
    case (decoded_rs_address)
      4'd13:   rs_sel = block_idx;
      4'd14:   rs_sel = BLOCK_DIM;
      4'd15:   rs_sel = THREAD_IDX;
      default: rs_sel = gpr[decoded_rs_address];
    endcase
  end

  always_comb begin
    rt_sel = '0;
    case (decoded_rt_address)
      4'd13:   rt_sel = block_idx;
      4'd14:   rt_sel = BLOCK_DIM;
      4'd15:   rt_sel = THREAD_IDX;
      default: rt_sel = gpr[decoded_rt_address];
    endcase
  end

  // Write port. The reserved mux code and writes aimed at R13-R15 are
  // dropped silently rather than flagged.
  always_comb begin
    wr_data = '0;
    case (decoded_reg_input_mux)
      SRC_ALU: wr_data = alu_out;
      SRC_LSU: wr_data = lsu_out;
      SRC_IMM: wr_data = decoded_immediate;
      default: wr_data = '0;
    endcase
  end

  assign wr_en = (core_state == STATE_UPDATE)
              && decoded_reg_write_enable
              && (decoded_rd_address <= LAST_GPR)
              && (decoded_reg_input_mux != 2'b11);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < NUM_GPR; i++) begin
        gpr[i] <= '0;
      end
      block_idx <= '0;
      rs        <= '0;
      rt        <= '0;
    end else if (enable) begin
      block_idx <= DATA_BITS'(block_id);
      // REQUEST and UPDATE are exclusive core states, so the read and write
      // ports never collide on one edge.
      if (core_state == STATE_REQUEST) begin
        rs <= rs_sel;
        rt <= rt_sel;
      end
      if (wr_en) begin
        gpr[decoded_rd_address] <= wr_data;
      end
    end
  end

endmodule

// File: tb/tb_thread_register_file.sv
// Directed bench for thread_register_file with THREAD_ID=2, 4 threads/block.
// Every edge a behavioural model predicts rs/rt; the prediction is queued at
// drive time and popped and compared after the edge.
module tb_thread_register_file;

  localparam int TPB = 4;
  localparam int TID = 2;

  localparam logic [2:0] S_IDLE    = 3'b000;
  localparam logic [2:0] S_REQUEST = 3'b011;
  localparam logic [2:0] S_WAIT    = 3'b100;
  localparam logic [2:0] S_EXECUTE = 3'b101;
  localparam logic [2:0] S_UPDATE  = 3'b110;

  logic       clk = 1'b0;
  logic       clk_en = 1'b0;
  logic       reset = 1'b1;
  logic       enable = 1'b0;
  logic [7:0] block_id = 8'd0;
  logic [2:0] core_state = S_IDLE;
  logic [3:0] rs_addr = 4'd0;
  logic [3:0] rt_addr = 4'd0;
  logic [3:0] rd_addr = 4'd0;
  logic       we = 1'b0;
  logic [1:0] mux = 2'b00;
  logic [7:0] imm = 8'd0;
  logic [7:0] alu_out = 8'd0;
  logic [7:0] lsu_out = 8'd0;
  logic [7:0] rs;
  logic [7:0] rt;

  always #5 clk = clk_en ? ~clk : clk;

  thread_register_file #(
    .THREADS_PER_BLOCK(TPB),
    .THREAD_ID(TID),
    .DATA_BITS(8)
  ) dut (
    .clk(clk),
    .reset(reset),
    .enable(enable),
    .block_id(block_id),
    .core_state(core_state),
    .decoded_rs_address(rs_addr),
    .decoded_rt_address(rt_addr),
    .decoded_rd_address(rd_addr),
    .decoded_reg_write_enable(we),
    .decoded_reg_input_mux(mux),
    .decoded_immediate(imm),
    .alu_out(alu_out),
    .lsu_out(lsu_out),
    .rs(rs),
    .rt(rt)
  );

  int checks = 0;
  int failures = 0;

  // Reference model state.
  logic [7:0] m_gpr [13];
  logic [7:0] m_r13;
  logic [7:0] m_rs;
  logic [7:0] m_rt;

  typedef struct {
    logic [7:0] rs;
    logic [7:0] rt;
  } exp_t;
  exp_t sb [$];

  function automatic logic [7:0] m_read(input logic [3:0] a);
    if (a == 4'd13) return m_r13;
    if (a == 4'd14) return 8'(TPB);
    if (a == 4'd15) return 8'(TID);
    return m_gpr[a];
  endfunction

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 13; i++) m_gpr[i] = 8'd0;
    m_r13 = 8'd0;
    m_rs  = 8'd0;
    m_rt  = 8'd0;
  endtask

  // Predict the edge, push the prediction, clock, then pop and compare.
  task automatic tick(input string tag);
    exp_t e;
    logic [7:0] src;
    if (enable) begin
      if (core_state == S_REQUEST) begin
        m_rs = m_read(rs_addr);
        m_rt = m_read(rt_addr);
      end
      if (core_state == S_UPDATE && we && rd_addr <= 4'd12 && mux != 2'b11) begin
        src = (mux == 2'b00) ? alu_out : (mux == 2'b01) ? lsu_out : imm;
        m_gpr[rd_addr] = src;
      end
      m_r13 = block_id;
    end
    e.rs = m_rs;
    e.rt = m_rt;
    sb.push_back(e);
    @(posedge clk);
    #1;
    e = sb.pop_front();
    chk({tag, ".rs"}, rs, e.rs);
    chk({tag, ".rt"}, rt, e.rt);
  endtask

  task automatic drive(input logic [2:0] st, input logic [3:0] a, input logic [3:0] b,
                       input logic [3:0] d, input logic w, input logic [1:0] m,
                       input logic [7:0] i);
    core_state = st;
    rs_addr    = a;
    rt_addr    = b;
    rd_addr    = d;
    we         = w;
    mux        = m;
    imm        = i;
  endtask

  initial begin
    model_reset();

    // Reset with no clock running: outputs clear asynchronously.
    #3 reset = 1'b0;
    #2;
    chk("reset.rs", rs, 8'd0);
    chk("reset.rt", rt, 8'd0);
    reset = 1'b1;
    #2;
    clk_en = 1'b1;
    enable = 1'b1;
    @(posedge clk);
    #1;
    drive(S_IDLE, 4'd0, 4'd0, 4'd0, 1'b0, 2'b00, 8'd0);
    m_r13 = block_id;  // first enabled edge already taken above

    drive(S_REQUEST, 4'd14, 4'd15, 4'd0, 1'b0, 2'b00, 8'd0);
    tick("req_dim_tid");
    chk("blockdim", rs, 8'd4);
    chk("threadidx", rt, 8'd2);

    // CONST write-back.
    drive(S_UPDATE, 4'd0, 4'd0, 4'd3, 1'b1, 2'b10, 8'd10);
    tick("upd_const");
    drive(S_REQUEST, 4'd3, 4'd0, 4'd0, 1'b0, 2'b00, 8'd0);
    tick("req_const");
    chk("const_r3", rs, 8'd10);
    chk("const_r0", rt, 8'd0);

    // ALU and LSU write-back, operands then held through EXECUTE.
    alu_out = 8'd15;
    drive(S_UPDATE, 4'd0, 4'd0, 4'd4, 1'b1, 2'b00, 8'd0);
    tick("upd_alu");
    lsu_out = 8'hAB;
    drive(S_UPDATE, 4'd0, 4'd0, 4'd5, 1'b1, 2'b01, 8'd0);
    tick("upd_lsu");
    drive(S_REQUEST, 4'd4, 4'd5, 4'd0, 1'b0, 2'b00, 8'd0);
    tick("req_alu_lsu");
    alu_out = 8'h3C;
    drive(S_WAIT, 4'd1, 4'd2, 4'd0, 1'b0, 2'b00, 8'd0);
    tick("wait_hold");
    drive(S_EXECUTE, 4'd1, 4'd2, 4'd0, 1'b0, 2'b00, 8'd0);
    tick("exec_hold");
    chk("exec_rs", rs, 8'd15);
    chk("exec_rt", rt, 8'hAB);

    // Protected and illegal writes.
    block_id = 8'd7;
    for (int r = 13; r <= 15; r++) begin
      drive(S_UPDATE, 4'd0, 4'd0, 4'(r), 1'b1, 2'b10, 8'h55);
      tick("upd_protected");
    end
    drive(S_UPDATE, 4'd0, 4'd0, 4'd6, 1'b1, 2'b11, 8'h55);
    tick("upd_mux11");
    drive(S_EXECUTE, 4'd0, 4'd0, 4'd7, 1'b1, 2'b10, 8'h77);
    tick("exec_write");
    drive(S_UPDATE, 4'd0, 4'd0, 4'd8, 1'b0, 2'b10, 8'h66);
    tick("upd_we0");
    drive(S_REQUEST, 4'd13, 4'd14, 4'd0, 1'b0, 2'b00, 8'd0);
    tick("req_r13_r14");
    chk("r13_blockidx", rs, 8'd7);
    chk("r14_blockdim", rt, 8'd4);
    drive(S_REQUEST, 4'd15, 4'd6, 4'd0, 1'b0, 2'b00, 8'd0);
    tick("req_r15_r6");
    chk("r15_tid", rs, 8'(TID));
    chk("r6_unwritten", rt, 8'd0);
    drive(S_REQUEST, 4'd7, 4'd8, 4'd0, 1'b0, 2'b00, 8'd0);
    tick("req_r7_r8");
    chk("r7_unwritten", rs, 8'd0);
    chk("r8_unwritten", rt, 8'd0);

    // R13 read on the same edge block_id changes returns the old value.
    block_id = 8'd9;
    drive(S_REQUEST, 4'd13, 4'd13, 4'd0, 1'b0, 2'b00, 8'd0);
    tick("req_r13_old");
    chk("r13_pre_edge", rs, 8'd7);

    // Enable gating.
    drive(S_REQUEST, 4'd3, 4'd4, 4'd0, 1'b0, 2'b00, 8'd0);
    tick("req_before_gate");
    enable   = 1'b0;
    block_id = 8'd3;
    drive(S_REQUEST, 4'd13, 4'd5, 4'd0, 1'b0, 2'b00, 8'd0);
    tick("gated_req");
    chk("gated_rs", rs, 8'd10);
    chk("gated_rt", rt, 8'd15);
    drive(S_UPDATE, 4'd0, 4'd0, 4'd2, 1'b1, 2'b10, 8'd9);
    tick("gated_upd");
    enable = 1'b1;
    drive(S_REQUEST, 4'd13, 4'd2, 4'd0, 1'b0, 2'b00, 8'd0);
    tick("ungate_req");
    chk("r13_held", rs, 8'd9);
    chk("r2_not_written", rt, 8'd0);
    drive(S_REQUEST, 4'd13, 4'd13, 4'd0, 1'b0, 2'b00, 8'd0);
    tick("req_r13_new");
    chk("r13_tracks", rs, 8'd3);

    // Async reset in the middle of an UPDATE.
    drive(S_UPDATE, 4'd0, 4'd0, 4'd1, 1'b1, 2'b10, 8'h42);
    tick("upd_r1");
    drive(S_REQUEST, 4'd1, 4'd1, 4'd0, 1'b0, 2'b00, 8'd0);
    tick("req_r1");
    chk("r1_preload", rs, 8'h42);
    drive(S_UPDATE, 4'd0, 4'd0, 4'd1, 1'b1, 2'b10, 8'h99);
    #2 reset = 1'b0;
    #1;
    chk("midreset.rs", rs, 8'd0);
    chk("midreset.rt", rt, 8'd0);
    model_reset();
    core_state = S_IDLE;
    #2 reset = 1'b1;
    @(posedge clk);
    #1;
    m_r13 = block_id;
    drive(S_REQUEST, 4'd1, 4'd14, 4'd0, 1'b0, 2'b00, 8'd0);
    tick("req_after_reset");
    chk("r1_cleared", rs, 8'd0);
    chk("r14_after_reset", rt, 8'd4);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/thread_register_file.md
# thread_register_file

Per-thread register file for one miniGPU compute lane, directly upstream and downstream of the ALU. It supplies the ALU's `rs`/`rt` operands during the REQUEST state of the core state machine. It writes back the ALU result, the LSU load data or a decoded immediate during UPDATE. Sixteen 8-bit registers per thread:
- R0–R12 are general purpose.
- R13–R15 are read-only: %blockIdx, %blockDim, %threadIdx.

## Interface
Parameters:
- THREADS_PER_BLOCK, 4, value reported in R14 (%blockDim)
- THREAD_ID, 0, lane index reported in R15 (%threadIdx); must be < THREADS_PER_BLOCK
- DATA_BITS, 8, register/operand width

Ports:
- clk  in  1  core clock; all state changes on rising edge
- reset  in  1  asynchronous, active-low reset; clears state immediately on assertion, released synchronously to clk by the core
- enable  in  1  lane active; when 0 all registers and outputs hold
- block_id  in  8  current block index, mirrored into R13
- core_state  in  3  000 IDLE, 001 FETCH, 010 DECODE, 011 REQUEST, 100 WAIT, 101 EXECUTE, 110 UPDATE, 111 DONE
- decoded_rs_address  in  4  source register A
- decoded_rt_address  in  4  source register B
- decoded_rd_address  in  4  destination register
- decoded_reg_write_enable  in  1  instruction writes rd
- decoded_reg_input_mux  in  2  write source: 00 alu_out, 01 lsu_out, 10 decoded_immediate, 11 reserved (no write)
- decoded_immediate  in  8  constant for CONST
- alu_out  in  8  ALU result
- lsu_out  in  8  load data
- rs  out  8  registered operand A to ALU/LSU
- rt  out  8  registered operand B to ALU/LSU

## Operation
- Reset (reset=0, asynchronous):
  - R0–R12 = 0, R13 = 0, R14 = THREADS_PER_BLOCK, R15 = THREAD_ID
  - rs = 0, rt = 0
- enable=0: no register, rs or rt changes in any state, including R13 refresh.
- enable=1, every edge: R13 <= block_id. R14/R15 are constant after reset.
- REQUEST (011):
  - rs <= R[decoded_rs_address]
  - rt <= R[decoded_rt_address]
  - Identical addresses return identical values.
  - Reads of R13 return the R13 value before the edge.
- UPDATE (110), decoded_reg_write_enable=1 and decoded_rd_address ≤ 12: R[rd] <= selected source per decoded_reg_input_mux.
- Writes are silently dropped in these cases:
  - mux=11
  - rd in 13..15
  - any state other than UPDATE
  - write_enable=0
- rs/rt hold their value in every state except REQUEST, so they are stable through WAIT, EXECUTE and UPDATE.
- No arithmetic is performed. Values are stored and returned bit-exact, with no sign or width conversion (all sources are DATA_BITS wide).
- Reset asserted mid-instruction (any state) clears everything at once; the pending write is lost.

## Timing
- Read latency: 1 cycle. rs/rt are valid the cycle after the REQUEST edge and remain valid until the next REQUEST.
- Write latency: 1 cycle. A value written at the UPDATE edge is visible to the next instruction's REQUEST read; there is no bypass path.
- R13 tracks block_id with 1-cycle delay while enable=1.
- Reset-to-output: combinational through the async clear, with no clock required.
- One write port and two read ports. REQUEST and UPDATE are mutually exclusive states, so there are no simultaneous read/write conflicts.

## Test plan
- Reset values:
  - Stimulus: THREAD_ID=2; pulse reset low without clk; then REQUEST with rs_addr=14, rt_addr=15.
  - Required: rs=rt=0 during reset; after the REQUEST edge, rs=4, rt=2.
- CONST write-back:
  - Stimulus: UPDATE with rd=3, mux=10, imm=10, we=1; then REQUEST with rs_addr=3, rt_addr=0.
  - Required: rs=10, rt=0.
- ALU and LSU write-back:
  - Stimulus: UPDATE rd=4, mux=00, alu_out=15; UPDATE rd=5, mux=01, lsu_out=0xAB; then REQUEST rs=4, rt=5.
  - Required: rs=15, rt=0xAB. A subsequent EXECUTE phase presents these operands unchanged to the ALU.
- Protected and illegal writes:
  - Stimulus: UPDATE with we=1 to rd=13/14/15 (imm=0x55, mux=10); UPDATE to rd=6 with mux=11; EXECUTE-state write to rd=7; block_id=7.
  - Required: R13 reads 7, R14 reads 4, R15 reads THREAD_ID, R6=0, R7=0.
- Enable gating:
  - Stimulus: enable=0 during REQUEST and UPDATE (rd=2, imm=9); change block_id to 3.
  - Required: rs/rt unchanged, R2 stays 0, R13 keeps its old value. After enable=1, R13=3 after one edge.
- Async reset mid-UPDATE:
  - Stimulus: preload R1=0x42; assert reset low between edges during an UPDATE to rd=1.
  - Required: rs/rt clear immediately. After release, R1 reads 0 and R14 reads 4.
